// File: rtl/mmio_io_port.sv
// I/O window decoder for the CPU data port: LED and HEX-digit registers, synchronised
// SW, debounced KEY levels and sticky KEY-press event flags.
module mmio_io_port #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] writedata,
    input  logic        memwrite,
    input  logic [3:0]  writemask,
    input  logic [3:0]  KEY,
    input  logic [9:0]  SW,
    output logic        is_io,
    output logic [31:0] io_readdata,
    output logic [9:0]  LEDR,
    output logic [23:0] hex_digits
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [3:0]  key_meta_reg, key_sync_reg;
    logic [9:0]  sw_meta_reg, sw_sync_reg;
    logic [3:0]  kst;
    logic [3:0]  key_press;
    logic [3:0]  keyev_reg, keyev_next;
    logic [9:0]  ledr_reg, ledr_next;
    logic [23:0] hex_reg, hex_next;
    logic        wr_en;
    logic        sel_leds, sel_hex, sel_keyev;
    logic        unused_bits;

    assign is_io     = addr[8];
    assign wr_en     = memwrite & addr[8];
    assign sel_leds  = wr_en & addr[2];
    assign sel_hex   = wr_en & addr[3];
    assign sel_keyev = wr_en & addr[6];

    assign unused_bits = ^{addr[31:9], addr[7], addr[1:0], writedata[31:24], writemask[3]};

    always_ff @(posedge clk) begin
        if (reset) begin
            key_meta_reg <= 4'hF;
            key_sync_reg <= 4'hF;
            sw_meta_reg  <= '0;
            sw_sync_reg  <= '0;
        end else begin
            key_meta_reg <= KEY;
            key_sync_reg <= key_meta_reg;
            sw_meta_reg  <= SW;
            sw_sync_reg  <= sw_meta_reg;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_debounce
            logic          kst_reg, kst_next, press;
            logic [CW-1:0] cnt_reg, cnt_next;

            always_comb begin
                kst_next = kst_reg;
                cnt_next = cnt_reg;
                press    = 1'b0;
                if (key_sync_reg[gi] == kst_reg) begin
                    cnt_next = '0;
                end else if (cnt_reg == CNT_MAX) begin
                    kst_next = key_sync_reg[gi];
                    cnt_next = '0;
                    // Accepting a low level while the stable level was high is a press.
                    press    = kst_reg;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    kst_reg <= 1'b1;
                    cnt_reg <= '0;
                end else begin
                    kst_reg <= kst_next;
                    cnt_reg <= cnt_next;
                end
            end

            assign kst[gi]       = kst_reg;
            assign key_press[gi] = press;
        end
    endgenerate

    always_comb begin
        ledr_next  = ledr_reg;
        hex_next   = hex_reg;
        keyev_next = keyev_reg;
        if (sel_leds && writemask[0]) ledr_next[7:0] = writedata[7:0];
        if (sel_leds && writemask[1]) ledr_next[9:8] = writedata[9:8];
        for (int n = 0; n < 3; n++) begin
            if (sel_hex && writemask[n]) hex_next[8*n +: 8] = writedata[8*n +: 8];
        end
        if (sel_keyev && writemask[0]) keyev_next = keyev_next & ~writedata[3:0];
        // Set after clear so a press on the same edge as its clear is kept.
        keyev_next = keyev_next | key_press;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ledr_reg  <= '0;
            hex_reg   <= '0;
            keyev_reg <= '0;
        end else begin
            ledr_reg  <= ledr_next;
            hex_reg   <= hex_next;
            keyev_reg <= keyev_next;
        end
    end

    always_comb begin
        io_readdata = '0;
        if (addr[8]) begin
            if (addr[4])      io_readdata = {28'b0, kst};
            else if (addr[5]) io_readdata = {22'b0, sw_sync_reg};
            else if (addr[6]) io_readdata = {28'b0, keyev_reg};
            else if (addr[2]) io_readdata = {22'b0, ledr_reg};
            else if (addr[3]) io_readdata = {8'b0, hex_reg};
        end
    end

    assign LEDR       = ledr_reg;
    assign hex_digits = hex_reg;

endmodule
